// File: rtl/int_queue_drain_pkg.sv
// Shared definitions for the interrupt-queue drain controller:
// FSM state encodings, default counter width and a clog2 helper.
package int_queue_drain_pkg;

  localparam int DEFAULT_CNT_WIDTH = 16;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_RD   = 2'd1;
  localparam logic [1:0] STATE_CAP  = 2'd2;
  localparam logic [1:0] STATE_HOLD = 2'd3;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/int_queue_drain_errflags.sv
// Sticky ECC flags for the drain controller; a capture-cycle set
// takes priority over a simultaneous host clear.
module int_queue_drain_errflags (
  input  logic clock,
  input  logic resetn,
  input  logic capture,
  input  logic sbIn,
  input  logic dbIn,
  input  logic errClr,
  output logic sbErr,
  output logic dbErr
);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sbErr <= 1'b0;
      dbErr <= 1'b0;
    end else begin
      if (capture && sbIn) begin
        sbErr <= 1'b1;
      end else if (errClr) begin
        sbErr <= 1'b0;
      end
      if (capture && dbIn) begin
        dbErr <= 1'b1;
      end else if (errClr) begin
        dbErr <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/int_queue_drain.sv
// Drains interrupt events from a queue one at a time and presents each
// to the host as a level interrupt until acknowledged.
module int_queue_drain
  import int_queue_drain_pkg::*;
#(
  parameter int FIFO_WIDTH = 8,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  fifoEmpty,
  input  logic [FIFO_WIDTH-1:0] rdData,
  input  logic                  error_flag_sb_fifo,
  input  logic                  error_flag_db_fifo,
  output logic                  rdEn,
  input  logic                  intClr,
  input  logic                  errClr,
  output logic                  interrupt,
  output logic [FIFO_WIDTH-1:0] intStatus,
  output logic                  sbErr,
  output logic                  dbErr,
  output logic [CNT_WIDTH-1:0]  srvCnt
);

  logic [1:0] state;

  // RD issues the pop, CAP waits for the queue's registered read data,
  // HOLD presents the event until the host acknowledges it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= STATE_IDLE;
      interrupt <= 1'b0;
      intStatus <= '0;
      srvCnt    <= '0;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (!fifoEmpty) begin
            state <= STATE_RD;
          end
        end
        STATE_RD: begin
          state <= STATE_CAP;
        end
        STATE_CAP: begin
          state     <= STATE_HOLD;
          intStatus <= rdData;
          interrupt <= 1'b1;
        end
        STATE_HOLD: begin
          if (intClr) begin
            interrupt <= 1'b0;
            srvCnt    <= srvCnt + CNT_WIDTH'(1);
            state     <= fifoEmpty ? STATE_IDLE : STATE_RD;
          end
        end
        default: begin
          state <= STATE_IDLE;
        end
      endcase
    end
  end

  assign rdEn = (state == STATE_RD);

  int_queue_drain_errflags errFlags (
    .clock   (clock),
    .resetn  (resetn),
    .capture (state == STATE_CAP),
    .sbIn    (error_flag_sb_fifo),
    .dbIn    (error_flag_db_fifo),
    .errClr  (errClr),
    .sbErr   (sbErr),
    .dbErr   (dbErr)
  );

endmodule

// File: tb/tb_int_queue_drain.sv
// Self-checking bench for int_queue_drain: a queue model feeds events and an
// event-level reference tracks expected words, sticky flags and service count.
module tb_int_queue_drain;

  localparam int FW = 8;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          resetn;
  logic          fifoEmpty;
  logic [FW-1:0] rdData;
  logic          sbFlag;
  logic          dbFlag;
  logic          rdEn;
  logic          intClr;
  logic          errClr;
  logic          interrupt;
  logic [FW-1:0] intStatus;
  logic          sbErr;
  logic          dbErr;
  logic [CW-1:0] srvCnt;

  int checks = 0;
  int errors = 0;
  int rdPulses = 0;

  logic [FW-1:0] fifoQ[$];
  bit            fifoSbQ[$];
  bit            fifoDbQ[$];
  logic [FW-1:0] expQ[$];
  bit            expSbQ[$];
  bit            expDbQ[$];
  int            expServed = 0;
  bit            expSb = 1'b0;
  bit            expDb = 1'b0;
  logic [FW-1:0] lastWord = '0;

  always #5 clock = ~clock;

  int_queue_drain #(.FIFO_WIDTH(FW), .CNT_WIDTH(CW)) dut (
    .clock              (clock),
    .resetn             (resetn),
    .fifoEmpty          (fifoEmpty),
    .rdData             (rdData),
    .error_flag_sb_fifo (sbFlag),
    .error_flag_db_fifo (dbFlag),
    .rdEn               (rdEn),
    .intClr             (intClr),
    .errClr             (errClr),
    .interrupt          (interrupt),
    .intStatus          (intStatus),
    .sbErr              (sbErr),
    .dbErr              (dbErr),
    .srvCnt             (srvCnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [FW-1:0] word, input bit sb, input bit db);
    fifoQ.push_back(word);
    fifoSbQ.push_back(sb);
    fifoDbQ.push_back(db);
    expQ.push_back(word);
    expSbQ.push_back(sb);
    expDbQ.push_back(db);
    fifoEmpty = 1'b0;
  endtask

  // One clock: the queue model answers a pop with data valid the next cycle.
  task automatic tick();
    bit popNow;
    popNow = (rdEn === 1'b1);
    if (popNow) rdPulses++;
    @(posedge clock);
    #1;
    if (popNow && fifoQ.size() > 0) begin
      rdData = fifoQ.pop_front();
      sbFlag = fifoSbQ.pop_front();
      dbFlag = fifoDbQ.pop_front();
    end
    fifoEmpty = (fifoQ.size() == 0);
    @(negedge clock);
  endtask

  task automatic captureCheck(input string tag);
    bit s;
    bit d;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s.noEvent observed=capture expected=none", tag);
    end else begin
      lastWord = expQ.pop_front();
      s = expSbQ.pop_front();
      d = expDbQ.pop_front();
      expSb = expSb | s;
      expDb = expDb | d;
      checkOutput({tag, ".interrupt"}, interrupt, 1);
      checkOutput({tag, ".intStatus"}, intStatus, lastWord);
      checkOutput({tag, ".sbErr"}, sbErr, expSb);
      checkOutput({tag, ".dbErr"}, dbErr, expDb);
    end
  endtask

  task automatic waitEvent(input string tag, input int expLat);
    int n;
    n = 0;
    while (interrupt !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput({tag, ".latency"}, n, expLat);
    captureCheck(tag);
  endtask

  task automatic ackEvent(input string tag, input bit withErrClr);
    intClr = 1'b1;
    errClr = withErrClr;
    tick();
    intClr = 1'b0;
    errClr = 1'b0;
    expServed++;
    if (withErrClr) begin
      expSb = 1'b0;
      expDb = 1'b0;
    end
    checkOutput({tag, ".ackInterrupt"}, interrupt, 0);
    checkOutput({tag, ".srvCnt"}, srvCnt, expServed % (1 << CW));
    checkOutput({tag, ".ackSbErr"}, sbErr, expSb);
    checkOutput({tag, ".ackDbErr"}, dbErr, expDb);
  endtask

  initial begin
    int  len;
    int  hold;
    bit  stableBad;

    resetn = 1'b0;
    fifoEmpty = 1'b1;
    rdData = '0;
    sbFlag = 1'b0;
    dbFlag = 1'b0;
    intClr = 1'b0;
    errClr = 1'b0;
    #2;
    checkOutput("reset.rdEn", rdEn, 0);
    checkOutput("reset.interrupt", interrupt, 0);
    checkOutput("reset.intStatus", intStatus, 0);
    checkOutput("reset.sbErr", sbErr, 0);
    checkOutput("reset.dbErr", dbErr, 0);
    checkOutput("reset.srvCnt", srvCnt, 0);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    tick();
    tick();
    checkOutput("idle.rdEn", rdEn, 0);

    $display("[TB] single event");
    rdPulses = 0;
    applyStimulus(8'hA5, 1'b0, 1'b0);
    waitEvent("single", 3);
    stableBad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (interrupt !== 1'b1 || intStatus !== 8'hA5) stableBad = 1'b1;
    end
    checkOutput("single.stable", stableBad, 0);
    checkOutput("single.rdPulses", rdPulses, 1);
    ackEvent("single", 1'b0);

    $display("[TB] back-to-back");
    rdPulses = 0;
    applyStimulus(8'h01, 1'b0, 1'b0);
    applyStimulus(8'h02, 1'b0, 1'b0);
    applyStimulus(8'h03, 1'b0, 1'b0);
    waitEvent("b2b0", 3);
    ackEvent("b2b0", 1'b0);
    waitEvent("b2b1", 2);
    ackEvent("b2b1", 1'b0);
    waitEvent("b2b2", 2);
    ackEvent("b2b2", 1'b0);
    checkOutput("b2b.rdPulses", rdPulses, 3);

    $display("[TB] spurious clear");
    intClr = 1'b1;
    tick();
    intClr = 1'b0;
    checkOutput("spurIdle.srvCnt", srvCnt, expServed % (1 << CW));
    checkOutput("spurIdle.interrupt", interrupt, 0);
    checkOutput("spurIdle.rdEn", rdEn, 0);
    applyStimulus(8'h3C, 1'b0, 1'b0);
    tick();
    tick();
    intClr = 1'b1;
    tick();
    intClr = 1'b0;
    captureCheck("spurCap");
    checkOutput("spurCap.srvCnt", srvCnt, expServed % (1 << CW));
    ackEvent("spurCap", 1'b0);

    $display("[TB] ECC set/clear priority");
    errClr = 1'b1;
    tick();
    errClr = 1'b0;
    expSb = 1'b0;
    expDb = 1'b0;
    applyStimulus(8'h5A, 1'b0, 1'b1);
    tick();
    tick();
    errClr = 1'b1;
    tick();
    errClr = 1'b0;
    captureCheck("ecc");
    errClr = 1'b1;
    tick();
    errClr = 1'b0;
    expSb = 1'b0;
    expDb = 1'b0;
    checkOutput("ecc.clearedDbErr", dbErr, 0);
    checkOutput("ecc.holdInterrupt", interrupt, 1);
    checkOutput("ecc.holdIntStatus", intStatus, 8'h5A);
    ackEvent("ecc", 1'b0);

    $display("[TB] randomized bursts");
    for (int b = 0; b < 8; b++) begin
      len = $urandom_range(1, 3);
      for (int i = 0; i < len; i++) begin
        applyStimulus(FW'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      end
      for (int i = 0; i < len; i++) begin
        waitEvent("rand", (i == 0) ? 3 : 2);
        hold = $urandom_range(0, 3);
        for (int h = 0; h < hold; h++) tick();
        checkOutput("rand.holdInterrupt", interrupt, 1);
        checkOutput("rand.holdIntStatus", intStatus, lastWord);
        ackEvent("rand", ($urandom_range(0, 2) == 0));
      end
    end

    $display("[TB] reset during CAP");
    applyStimulus(8'hC3, 1'b1, 1'b1);
    tick();
    tick();
    resetn = 1'b0;
    #1;
    checkOutput("midReset.rdEn", rdEn, 0);
    checkOutput("midReset.interrupt", interrupt, 0);
    checkOutput("midReset.intStatus", intStatus, 0);
    checkOutput("midReset.sbErr", sbErr, 0);
    checkOutput("midReset.dbErr", dbErr, 0);
    checkOutput("midReset.srvCnt", srvCnt, 0);
    void'(expQ.pop_front());
    void'(expSbQ.pop_front());
    void'(expDbQ.pop_front());
    expServed = 0;
    expSb = 1'b0;
    expDb = 1'b0;
    @(negedge clock);
    tick();
    resetn = 1'b1;
    rdPulses = 0;
    for (int i = 0; i < 5; i++) tick();
    checkOutput("postReset.rdPulses", rdPulses, 0);
    checkOutput("postReset.interrupt", interrupt, 0);

    $display("[TB] counter wrap");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(FW'(i + 16), 1'b0, 1'b0);
    end
    for (int i = 0; i < 17; i++) begin
      waitEvent("wrap", (i == 0) ? 3 : 2);
      ackEvent("wrap", 1'b0);
    end
    checkOutput("wrap.final", srvCnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_queue_drain.md
INT_QUEUE_DRAIN -- requirements
Module: int_queue_drain

Interface
- REQ-001 Parameter FIFO_WIDTH, default 8, width of one interrupt event word popped from the interrupt queue.
- REQ-002 Parameter CNT_WIDTH, default 16, width of the serviced-event counter.
- REQ-003 clock  input  1  single clock; all logic on rising edge.
- REQ-004 resetn  input  1  reset, asynchronous and active-low.
- REQ-005 fifoEmpty  input  1  queue empty flag from the interrupt queue.
- REQ-006 rdData  input  FIFO_WIDTH  queue read data; valid in the cycle after the rdEn cycle.
- REQ-007 error_flag_sb_fifo  input  1  queue single-bit ECC corrected, aligned with rdData.
- REQ-008 error_flag_db_fifo  input  1  queue double-bit ECC detected, aligned with rdData.
- REQ-009 rdEn  output  1  pop strobe to the queue; one cycle per event.
- REQ-010 intClr  input  1  host acknowledge of the presented event.
- REQ-011 errClr  input  1  host clear of the sticky ECC flags.
- REQ-012 interrupt  output  1  level interrupt to the host; high while an event is presented.
- REQ-013 intStatus  output  FIFO_WIDTH  presented event word.
- REQ-014 sbErr  output  1  sticky single-bit-corrected flag.
- REQ-015 dbErr  output  1  sticky double-bit-detected flag.
- REQ-016 srvCnt  output  CNT_WIDTH  count of events acknowledged since reset.

Function
- REQ-017 The FSM SHALL have four states: IDLE, RD, CAP, HOLD.
- REQ-018 IDLE -> RD when fifoEmpty=0; otherwise remain in IDLE.
- REQ-019 rdEn SHALL equal 1 only in RD, decoded from the state register, so exactly one pop is issued per RD visit.
- REQ-020 RD -> CAP unconditionally; no pop occurs in CAP.
- REQ-021 On the CAP -> HOLD edge the block SHALL load intStatus<=rdData and set interrupt<=1.
- REQ-022 In HOLD, intStatus and interrupt SHALL stay stable until intClr=1.
- REQ-023 HOLD with intClr=1 SHALL do the following on the same edge: clear interrupt, increment srvCnt, then go to RD if fifoEmpty=0 (back-to-back service) or to IDLE otherwise.
- REQ-024 interrupt SHALL be low for at least one cycle between consecutive events (RD, CAP).
- REQ-025 intClr outside HOLD SHALL be ignored.
- REQ-026 srvCnt SHALL wrap modulo 2^CNT_WIDTH without saturation.
- REQ-027 error_flag_sb_fifo/db_fifo SHALL be sampled only in CAP; a 1 sets sbErr/dbErr respectively.
- REQ-028 intStatus SHALL be loaded even when a double-bit error is flagged.
- REQ-029 errClr SHALL clear both sticky flags.
- REQ-030 Set in CAP and errClr in the same cycle: set wins.
- REQ-031 Event-to-interrupt latency from the IDLE cycle with fifoEmpty=0 SHALL be 3 edges (IDLE->RD->CAP->HOLD).

Reset
- REQ-032 resetn low SHALL asynchronously force: state=IDLE, rdEn=0, interrupt=0, intStatus=0, sbErr=0, dbErr=0, srvCnt=0.
- REQ-033 Reset asserted in RD or CAP SHALL discard the popped event, with no re-pop after release.
- REQ-034 Operation SHALL resume from IDLE on the first rising edge after resetn deasserts.

Structure
- REQ-035 State encodings and the default CNT_WIDTH SHALL live in the shared controller package/utility include alongside clog2().
- REQ-036 A single sub-module int_queue_drain_errflags SHALL hold the two sticky ECC flags with their set/clear priority; everything else SHALL be flat.

Verification
- REQ-037 Single event: queue holds 0xA5, no clears -> rdEn high exactly one cycle; interrupt=1 and intStatus=0xA5 on the 3rd edge; stable for 20 cycles.
- REQ-038 Back-to-back: queue holds 0x01, 0x02, 0x03; intClr pulsed in each HOLD -> three rdEn pulses; intStatus sequence 0x01, 0x02, 0x03; interrupt low 2 cycles between events; srvCnt=3.
- REQ-039 Spurious clear: intClr=1 while IDLE and while in CAP -> no state change, srvCnt unchanged.
- REQ-040 ECC: error_flag_db_fifo=1 in CAP with errClr=1 same cycle -> dbErr=1 after the edge; errClr alone next cycle -> dbErr=0; intStatus still loaded.
- REQ-041 Reset mid-op: resetn low during CAP -> all outputs 0 immediately; after release with fifoEmpty=1, rdEn stays 0.
- REQ-042 Wrap: CNT_WIDTH=4, 17 events serviced -> srvCnt=1.
